// File: rtl/dma_copy_master.sv
`default_nettype none
// ============================================================================
// dma_copy_master : single-channel word-copy engine, one bus transaction at a time
// Revision 1.0
// ============================================================================
module dma_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  output logic [3:0]       sel_o,
  output logic             we_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  logic [31:0]      data_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_REQ = 3'd1;
  localparam logic [2:0] S_RD_RSP = 3'd2;
  localparam logic [2:0] S_WR_REQ = 3'd3;
  localparam logic [2:0] S_WR_RSP = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             last_word;

  assign last_word = (rem_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = (len_i != '0) ? S_RD_REQ : S_DONE;
      S_RD_REQ: if (req_ready_i) state_d = S_RD_RSP;
      S_RD_RSP: if (rsp_valid_i) state_d = S_WR_REQ;
      S_WR_REQ: if (req_ready_i) state_d = S_WR_RSP;
      S_WR_RSP: if (rsp_valid_i) state_d = last_word ? S_DONE : S_RD_REQ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // addr_q/data_q are loaded on the edge entering a request state, so they
  // stay frozen for the whole request and hold their value afterwards.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    addr_d = addr_q;
    data_d = data_q;
    rem_d  = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          src_d  = src_addr_i & WORD_MASK;
          dst_d  = dst_addr_i & WORD_MASK;
          rem_d  = len_i;
          addr_d = src_addr_i & WORD_MASK;
        end
      end
      S_RD_RSP: begin
        if (rsp_valid_i) begin
          data_d = data_i;
          addr_d = dst_q;
        end
      end
      S_WR_RSP: begin
        if (rsp_valid_i) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          rem_d = rem_q - LEN_W'(1);
          if (!last_word) addr_d = src_q + 32'd4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rem_q  <= rem_d;
    end
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    req_valid_o = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    we_o        = (state_q == S_WR_REQ);
    rsp_ready_o = (state_q == S_RD_RSP) || (state_q == S_WR_RSP);
    addr_o      = addr_q;
    data_o      = data_q;
    sel_o       = 4'b1111;
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_master.sv
`default_nettype none
// ============================================================================
// tb_dma_copy_master : scoreboard bench with a behavioural memory responder
// Revision 1.0
// ============================================================================
module tb_dma_copy_master;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [31:0]      src_addr_i;
  logic [31:0]      dst_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      addr_o;
  logic [31:0]      data_o;
  logic [3:0]       sel_o;
  logic             we_o;
  logic             req_valid_o;
  logic             req_ready_i;
  logic [31:0]      data_i;
  logic             rsp_valid_i;
  logic             rsp_ready_o;

  dma_copy_master #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .sel_o      (sel_o),
    .we_o       (we_o),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .data_i     (data_i),
    .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks;
  int          errors;
  int          hs_cnt;
  int          done_cnt;
  bit          stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Memory responder: decides ready/valid at negedge for the following posedge
  initial begin
    bit          pend;
    logic [31:0] pend_data;
    int          rsp_wait;
    int          req_wait;
    pend = 0; pend_data = 0; rsp_wait = 0; req_wait = 0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; data_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; req_wait = 0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; data_i = 32'h0;
      end else begin
        if (rsp_valid_i) begin
          rsp_valid_i = 1'b0;
          data_i      = 32'h0;
        end else if (pend) begin
          if (rsp_wait == 0) begin
            rsp_valid_i = 1'b1;
            data_i      = pend_data;
            pend        = 0;
          end else begin
            rsp_wait--;
          end
        end
        req_ready_i = 1'b0;
        if (req_valid_o && !pend && !rsp_valid_i) begin
          if (req_wait == 0) begin
            req_ready_i = 1'b1;
            if (we_o) begin
              mem[addr_o] = data_o;
              pend_data   = 32'h0;
            end else begin
              pend_data = rd_mem(addr_o);
            end
            pend     = 1;
            rsp_wait = stall ? int'($urandom_range(0, 5)) : 0;
            req_wait = stall ? int'($urandom_range(0, 5)) : 0;
          end else begin
            req_wait--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every request handshake
  initial begin
    req_t        e;
    bit          prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic        prev_we;
    prev_pending = 0; prev_addr = 0; prev_data = 0; prev_we = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_pending = 0;
      end else begin
        if (done_o) done_cnt++;
        if (req_valid_o && prev_pending) begin
          chk("stable_addr", addr_o, prev_addr);
          chk("stable_data", data_o, prev_data);
          chk("stable_we", 32'(we_o), 32'(prev_we));
        end
        if (req_valid_o && req_ready_i) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req addr=%h we=%b required=none", addr_o, we_o);
          end else begin
            e = exp_q.pop_front();
            chk("req_addr", addr_o, e.addr);
            chk("req_we", 32'(we_o), 32'(e.we));
            chk("req_sel", 32'(sel_o), 32'hF);
            if (e.we) chk("req_wdata", data_o, e.data);
          end
        end
        prev_pending = req_valid_o && !req_ready_i;
        prev_addr    = addr_o;
        prev_data    = data_o;
        prev_we      = we_o;
      end
    end
  end

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] s;
    logic [31:0] d;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{addr: s, we: 1'b0, data: 32'h0});
      exp_q.push_back('{addr: d, we: 1'b1, data: rd_mem(s)});
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // Starts a copy, optionally pulses start during busy, returns done latency
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit busy_pulses, output int lat);
    int d0;
    d0 = done_cnt;
    push_copy(src, dst, len);
    @(negedge clk);
    src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(len); start_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start_i = busy_pulses && (lat == 2 || lat == 5);
      if (start_i) begin
        src_addr_i = 32'h0000_9000; dst_addr_i = 32'h0000_A000; len_i = LEN_W'(3);
      end
    end while (!done_o && lat < 3000);
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none required=done_o");
    end
    // start presented during the DONE cycle must be ignored
    src_addr_i = 32'h0000_9000; dst_addr_i = 32'h0000_A000; len_i = LEN_W'(5);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("idle_busy", 32'(busy_o), 32'h0);
    chk("idle_done", 32'(done_o), 32'h0);
    @(negedge clk);
    chk("idle_busy2", 32'(busy_o), 32'h0);
    chk("idle_req_valid", 32'(req_valid_o), 32'h0);
    chk("done_pulses", 32'(done_cnt - d0), 32'h1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_req_valid"}, 32'(req_valid_o), 32'h0);
    chk({tag, "_rsp_ready"}, 32'(rsp_ready_o), 32'h0);
    chk({tag, "_we"}, 32'(we_o), 32'h0);
    chk({tag, "_addr"}, addr_o, 32'h0);
    chk({tag, "_data"}, data_o, 32'h0);
    chk({tag, "_sel"}, 32'(sel_o), 32'hF);
  endtask

  initial begin
    int lat;
    int h0;
    int d0;
    int n;
    checks = 0; errors = 0; hs_cnt = 0; done_cnt = 0; stall = 0;
    rst = 1'b1; start_i = 1'b0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 4-word zero-wait copy
    mem[32'h100] = 32'h1111_1111; mem[32'h104] = 32'h2222_2222;
    mem[32'h108] = 32'h3333_3333; mem[32'h10C] = 32'h4444_4444;
    h0 = hs_cnt;
    run_copy(32'h100, 32'h200, 4, 0, lat);
    chk("lat_4w", 32'(lat), 32'd17);
    chk("hs_4w", 32'(hs_cnt - h0), 32'd8);
    chk("dst_w0", rd_mem(32'h200), 32'h1111_1111);
    chk("dst_w1", rd_mem(32'h204), 32'h2222_2222);
    chk("dst_w2", rd_mem(32'h208), 32'h3333_3333);
    chk("dst_w3", rd_mem(32'h20C), 32'h4444_4444);

    // zero length
    h0 = hs_cnt;
    run_copy(32'h100, 32'h300, 0, 0, lat);
    chk("lat_len0", 32'(lat), 32'd1);
    chk("hs_len0", 32'(hs_cnt - h0), 32'd0);

    // 16-word copy with random stalls
    for (int i = 0; i < 16; i++) mem[32'h1000 + 32'(4 * i)] = 32'hA500_0000 + 32'(i * 32'h0101_0101);
    stall = 1;
    h0 = hs_cnt;
    run_copy(32'h1000, 32'h2000, 16, 0, lat);
    stall = 0;
    chk("hs_16w", 32'(hs_cnt - h0), 32'd32);
    for (int i = 0; i < 16; i++)
      chk("dst_16w", rd_mem(32'h2000 + 32'(4 * i)), 32'hA500_0000 + 32'(i * 32'h0101_0101));

    // misaligned source, destination wraps past 2^32
    run_copy(32'h0000_0103, 32'hFFFF_FFFC, 2, 0, lat);
    chk("wrap_w0", rd_mem(32'hFFFF_FFFC), 32'h1111_1111);
    chk("wrap_w1", rd_mem(32'h0000_0000), 32'h2222_2222);

    // reset during WR_REQ of word 3 of 8
    for (int i = 0; i < 8; i++) mem[32'h5000 + 32'(4 * i)] = 32'h5A5A_0000 + 32'(i);
    d0 = done_cnt;
    push_copy(32'h5000, 32'h6000, 8);
    @(negedge clk);
    src_addr_i = 32'h5000; dst_addr_i = 32'h6000; len_i = LEN_W'(8); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(req_valid_o && we_o && addr_o == 32'h6008) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr3", 32'(n < 200), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'h0);
    chk("midrst_idle", 32'(busy_o), 32'h0);

    // fresh copy after reset, with start pulses while busy
    for (int i = 0; i < 4; i++) mem[32'h7000 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i * 7);
    h0 = hs_cnt;
    run_copy(32'h7000, 32'h8000, 4, 1, lat);
    chk("lat_busy_pulse", 32'(lat), 32'd17);
    chk("hs_busy_pulse", 32'(hs_cnt - h0), 32'd8);
    for (int i = 0; i < 4; i++)
      chk("dst_after_rst", rd_mem(32'h8000 + 32'(4 * i)), 32'hC0DE_0000 + 32'(i * 7));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_copy_master.md
# dma_copy_master

Single-channel word-copy engine acting as a bus initiator on the core's valid/ready request/response memory protocol. Given a source address, destination address and word count, it reads each word from the source through one request/response exchange and writes it to the destination through a second exchange, with one transaction outstanding at a time. It sits between a control register block (start/config) and a memory responder such as the on-chip data RAM.

## Interface
- LEN_W, 16, width of the word-count field; maximum copy is 2^LEN_W-1 words
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle start strobe; sampled only in IDLE
- src_addr_i  input  32  source byte address; bits [1:0] forced to 0 internally
- dst_addr_i  input  32  destination byte address; bits [1:0] forced to 0 internally
- len_i  input  LEN_W  number of 32-bit words to copy
- busy_o  output  1  high from the cycle after an accepted start through DONE
- done_o  output  1  one-cycle pulse when the copy completes
- addr_o  output  32  request byte address
- data_o  output  32  write data (valid with write requests)
- sel_o  output  4  byte enables; always 4'b1111
- we_o  output  1  1 = write request, 0 = read request
- req_valid_o  output  1  request valid
- req_ready_i  input  1  responder accepts request
- data_i  input  32  read data from responder
- rsp_valid_i  input  1  response valid
- rsp_ready_o  output  1  initiator accepts response

## Operation
- States: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE.
- IDLE: start_i=1 and len_i!=0 -> latch src/dst (low 2 bits zeroed) and len into counters, go RD_REQ. start_i=1 and len_i==0 -> go DONE directly (no bus traffic). start_i outside IDLE ignored.
- RD_REQ: req_valid_o=1, we_o=0, addr_o=src pointer. On req_valid_o&req_ready_i -> RD_RSP.
- RD_RSP: rsp_ready_o=1. On rsp_valid_i -> capture data_i into data buffer, go WR_REQ.
- WR_REQ: req_valid_o=1, we_o=1, addr_o=dst pointer, data_o=buffer. On handshake -> WR_RSP.
- WR_RSP: rsp_ready_o=1. On rsp_valid_i -> src+=4, dst+=4, remaining-=1; remaining was 1 -> DONE, else RD_REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Pointers wrap modulo 2^32 (32-bit add, carry discarded).
- Request stability: once req_valid_o is high, addr_o/data_o/we_o/sel_o held constant until the handshake cycle; req_valid_o never deasserts before acceptance.
- rsp_ready_o is 0 in all states other than RD_RSP/WR_RSP; a response arriving in another state is not consumed.
- Outside RD_REQ/WR_REQ: req_valid_o=0, we_o=0; addr_o/data_o hold last value.

## Timing
- Reset (rst=1 at a clk edge): state IDLE; busy_o=0, done_o=0, req_valid_o=0, rsp_ready_o=0, we_o=0, addr_o=0, data_o=0, sel_o=4'b1111, counters cleared. Reset mid-copy abandons the transfer immediately; no done_o pulse.
- All outputs registered or decoded from registered state only; no combinational path from req_ready_i/rsp_valid_i to any output.
- req_valid_o rises the cycle after start_i is sampled.
- Zero-wait responder (req_ready_i=1, rsp_valid_i one cycle after acceptance): 4 cycles per word; copy of N words: done_o asserts 4N+1 cycles after the start_i cycle. len=0: done_o asserts the cycle after start_i.
- busy_o=1 in every non-IDLE state, including the DONE cycle.
- Simultaneous start_i in the DONE cycle: ignored; new start must arrive in IDLE.

## Test plan
- Copy 4 words src=0x0000_0100 to dst=0x0000_0200 with zero-wait RAM model preloaded 0x11111111..0x44444444 -> dst words equal source, done_o pulses once at cycle 17 after start, busy_o then 0.
- len=0, start_i=1 -> no req_valid_o, done_o high the next cycle only.
- Random req_ready_i/rsp_valid_i stalls (0-5 cycles) on 16-word copy -> addr_o/data_o/we_o stable while req_valid_o&!req_ready_i, data intact, exactly 32 request handshakes.
- src=0x0000_0103, dst=0xFFFF_FFFC, len=2 -> read addrs 0x100, 0x104; write addrs 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst during WR_REQ of word 3 of 8 -> next cycle all outputs at reset values, no done_o; new start then copies correctly.
- start_i pulses during busy -> ignored; single done_o, counts unchanged.
